// File: rtl/led_pkg.sv
// Shared widths and the per-channel level type for the LED fade driver.
package led_pkg;
  localparam int LED_COUNT = 8;
  localparam int PWM_BITS  = 8;
  typedef logic [PWM_BITS-1:0] level_t;
endpackage

// File: rtl/led_fade_driver_if.sv
// Upstream pattern bus: LED pattern, its qualifying strobe and the global brightness.
interface led_fade_driver_if;
  import led_pkg::*;
  logic [LED_COUNT-1:0] led_in;
  logic                 led_in_valid;
  level_t               brightness;

  modport master (output led_in, output led_in_valid, output brightness);
  modport slave  (input  led_in, input  led_in_valid, input  brightness);
endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level register and registered active-low PWM compare.
// Fading on target release is enabled by LED_FADE_DRIVER_FADE_EN.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int FADE_STEP = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   target,
`ifdef LED_FADE_DRIVER_FADE_EN
  input  logic   fade_tick,
`endif
  input  level_t brightness,
  input  level_t pwm_cnt,
  output logic   led_n
);

  level_t level;

`ifdef LED_FADE_DRIVER_FADE_EN
  localparam level_t STEP = level_t'(FADE_STEP);

  function automatic level_t sat_sub(input level_t a, input level_t b);
    return (a > b) ? level_t'(a - b) : '0;
  endfunction
`endif

  // stage p1 -> p2: level follows the registered target; stage p2 -> p3: PWM compare
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      led_n <= 1'b1;
    end else begin
      if (target) begin
        level <= brightness;
`ifdef LED_FADE_DRIVER_FADE_EN
      end else if (fade_tick) begin
        level <= sat_sub(level, STEP);
`else
      end else begin
        level <= '0;
`endif
      end
      led_n <= ~(level > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_fade_driver.sv
// Eight-channel LED PWM driver with shared PWM counter and fade prescaler.
// Fade-out on pattern release is built only when LED_FADE_DRIVER_FADE_EN is defined.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int FADE_DIV  = 50000,
  parameter int FADE_STEP = 4
) (
  input  logic                 clk_50mhz,
  input  logic                 rst,
  led_fade_driver_if.slave     up,
  output logic [LED_COUNT-1:0] led_n
);

  level_t               pwm_cnt;
  logic [LED_COUNT-1:0] target;

  // stage p0 -> p1: capture pattern; PWM phase is shared by every channel
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      pwm_cnt <= '0;
      target  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + level_t'(1);
      if (up.led_in_valid) target <= up.led_in;
    end
  end

`ifdef LED_FADE_DRIVER_FADE_EN
  localparam int PW = $clog2(FADE_DIV);

  logic [PW-1:0] presc;
  logic          fade_tick;

  assign fade_tick = (presc == PW'(FADE_DIV - 1));

  always_ff @(posedge clk_50mhz) begin
    if (rst || fade_tick) presc <= '0;
    else                  presc <= presc + PW'(1);
  end
`endif

  for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
    led_fade_channel #(
      .FADE_STEP (FADE_STEP)
    ) u_ch (
      .clk        (clk_50mhz),
      .rst        (rst),
      .target     (target[i]),
`ifdef LED_FADE_DRIVER_FADE_EN
      .fade_tick  (fade_tick),
`endif
      .brightness (up.brightness),
      .pwm_cnt    (pwm_cnt),
      .led_n      (led_n[i])
    );
  end

endmodule
